// File: rtl/pc_sequencer.sv
// Program-counter sequencer: hold/inc/jump/branch/call/ret with an internal return-address stack.
// Optional macro PC_LIMIT_EN: redirect out-of-range next pc to RESET_VEC and pulse fault.
module pc_sequencer #(
  parameter int unsigned AW        = 8,
  parameter int unsigned STEP      = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned LIMIT     = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] offset,
  output logic [AW-1:0] pc,
  output logic          stack_empty,
  output logic          stack_full,
  output logic          err,
  output logic          fault
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0]  RESET_PC = AW'(RESET_VEC);
  localparam logic [AW-1:0]  LIMIT_PC = AW'(LIMIT);
  localparam logic [AW-1:0]  STEP_PC  = AW'(STEP);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE   = SPW'(1);

`ifdef PC_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_JUMP   = 3'b010,
    OP_BRANCH = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101
  } op_e;

  logic [AW-1:0]  stack [DEPTH];
  logic [SPW-1:0] sp, sp_d;
  logic [AW-1:0]  pc_d, pc_calc;
  logic           push, err_d, fault_d;
  logic [IW-1:0]  wr_idx, rd_idx;

  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - SP_ONE);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    pc_calc = pc;
    sp_d    = sp;
    push    = 1'b0;
    err_d   = 1'b0;
    fault_d = 1'b0;
    pc_d    = pc;
    if (en) begin
      unique case (op)
        OP_HOLD:   pc_calc = pc;
        OP_INC:    pc_calc = pc + STEP_PC;
        OP_JUMP:   pc_calc = target;
        OP_BRANCH: pc_calc = pc + offset;  // two's-complement add wraps naturally
        OP_CALL: begin
          pc_calc = target;
          if (sp == SP_FULL) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            sp_d = sp + SP_ONE;
          end
        end
        OP_RET: begin
          if (sp == '0) begin
            err_d = 1'b1;
          end else begin
            pc_calc = stack[rd_idx];
            sp_d    = sp - SP_ONE;
          end
        end
        default:   err_d = 1'b1;  // reserved ops behave as HOLD
      endcase
      pc_d = pc_calc;
      if (LIMIT_EN && (pc_calc > LIMIT_PC)) begin
        pc_d    = RESET_PC;
        fault_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      sp          <= '0;
      stack_empty <= 1'b1;
      stack_full  <= 1'b0;
      err         <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pc          <= pc_d;
      sp          <= sp_d;
      stack_empty <= (sp_d == '0);
      stack_full  <= (sp_d == SP_FULL);
      err         <= err_d;
      fault       <= fault_d;
    end
  end

  // NOTE: the stack array is not reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack[wr_idx] <= pc + STEP_PC;
    end
  end

endmodule
